// File: rtl/fetch_unit.sv
// Fetch front end: in-order requests to variable-latency imem, buffered words presented with PC; output is valid one cycle after the response.
// Backpressure: stall_F holds the buffer head; issue stops when in-flight live requests plus buffered words would exceed DEPTH.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        PC_src_D,
  input  logic [31:0] PC_Target_D,
  input  logic        stall_F,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid_F,
  output logic [31:0] instr_F,
  output logic [31:0] PC_F,
  output logic [31:0] PC_plus4_F
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW:0] DEPTH_W = DEPTH[CW:0];

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_resp_pc;
  logic [CW-1:0] r_out_cnt;
  logic [CW-1:0] r_drop_cnt;
  logic [CW-1:0] r_buf_cnt;
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  entry_t        r_buf [DEPTH];

  logic [CW:0]   w_credit_use;
  logic          w_issue;
  logic          w_resp;
  logic          w_keep;
  logic          w_pop;
  logic [31:0]   w_target;
  logic [CW-1:0] w_out_nxt;
  logic [CW-1:0] w_buf_nxt;
  entry_t        w_head;
  logic          w_unused_tgt_lsb;

  assign w_unused_tgt_lsb = ^PC_Target_D[1:0];
  assign w_target         = {PC_Target_D[31:2], 2'b00};

  // Credit uses registered counts only, so a pop in this cycle frees space next cycle.
  assign w_credit_use = {1'b0, r_out_cnt - r_drop_cnt} + {1'b0, r_buf_cnt};
  assign imem_req     = rst_n && !PC_src_D
                        && ({1'b0, r_out_cnt} < DEPTH_W)
                        && (w_credit_use < DEPTH_W);
  assign imem_addr    = r_fetch_pc;

  assign w_issue = imem_req && imem_gnt;
  assign w_resp  = imem_rvalid && (r_out_cnt != '0);
  assign w_keep  = w_resp && !PC_src_D && (r_drop_cnt == '0);
  assign w_pop   = instr_valid_F && !stall_F && !PC_src_D;

  always_comb begin
    w_out_nxt = r_out_cnt;
    if (w_issue) w_out_nxt = w_out_nxt + 1'b1;
    if (w_resp)  w_out_nxt = w_out_nxt - 1'b1;
  end

  always_comb begin
    w_buf_nxt = r_buf_cnt;
    if (w_keep) w_buf_nxt = w_buf_nxt + 1'b1;
    if (w_pop)  w_buf_nxt = w_buf_nxt - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC;
      r_resp_pc  <= RESET_PC;
      r_out_cnt  <= '0;
      r_drop_cnt <= '0;
      r_buf_cnt  <= '0;
      r_head     <= '0;
      r_tail     <= '0;
    end else if (PC_src_D) begin
      // Everything still outstanding after this cycle's response belongs to the old path.
      r_fetch_pc <= w_target;
      r_resp_pc  <= w_target;
      r_out_cnt  <= w_out_nxt;
      r_drop_cnt <= w_out_nxt;
      r_buf_cnt  <= '0;
      r_head     <= '0;
      r_tail     <= '0;
    end else begin
      if (w_issue) r_fetch_pc <= r_fetch_pc + 32'd4;
      r_out_cnt <= w_out_nxt;
      if (w_resp && (r_drop_cnt != '0)) r_drop_cnt <= r_drop_cnt - 1'b1;
      if (w_keep) begin
        r_tail    <= r_tail + 1'b1;
        r_resp_pc <= r_resp_pc + 32'd4;
      end
      if (w_pop) r_head <= r_head + 1'b1;
      r_buf_cnt <= w_buf_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_keep) r_buf[r_tail] <= '{pc: r_resp_pc, instr: imem_rdata};
  end

  assign w_head        = r_buf[r_head];
  assign instr_valid_F = (r_buf_cnt != '0);
  assign instr_F       = instr_valid_F ? w_head.instr : 32'h0;
  assign PC_F          = instr_valid_F ? w_head.pc : 32'h0;
  assign PC_plus4_F    = PC_F + 32'd4;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: vector tables for streaming/stall, hand sequences for redirect and reset corners.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        PC_src_D = 1'b0;
  logic [31:0] PC_Target_D = 32'h0;
  logic        stall_F = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b1;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        instr_valid_F;
  logic [31:0] instr_F;
  logic [31:0] PC_F;
  logic [31:0] PC_plus4_F;

  int n_vec = 0;
  int n_bad = 0;
  int lat = 1;
  int ec = 0;
  int stray_req = 0;
  int stray_seen = 0;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;
  pend_t q[$];
  logic  from_q;

  typedef struct {
    logic        stall;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc;
  } vec_t;
  vec_t tab_a [8];
  vec_t tab_b [16];

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .PC_src_D(PC_src_D), .PC_Target_D(PC_Target_D),
    .stall_F(stall_F), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr_valid_F(instr_valid_F),
    .instr_F(instr_F), .PC_F(PC_F), .PC_plus4_F(PC_plus4_F)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  // In-order memory: responds lat cycles after the grant cycle; stray_req injects one unsolicited response.
  always begin
    @(negedge clk);
    ec = ec + 1;
    from_q = 1'b0;
    if (stray_req != stray_seen) begin
      stray_seen  = stray_req;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;
    end else if (q.size() > 0 && q[0].due <= ec) begin
      imem_rvalid = 1'b1;
      imem_rdata  = word_of(q[0].addr);
      from_q      = 1'b1;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
    end
    #2;
    if (!rst_n) begin
      q.delete();
    end else begin
      if (from_q) void'(q.pop_front());
      if (imem_req && imem_gnt) q.push_back('{addr: imem_addr, due: ec + lat});
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input logic req, input logic [31:0] addr,
                         input logic vld, input logic [31:0] pc);
    logic [31:0] e_pc;
    e_pc = vld ? pc : 32'h0;
    chk({tag, "_req"},   32'(imem_req), 32'(req));
    chk({tag, "_addr"},  imem_addr, addr);
    chk({tag, "_vld"},   32'(instr_valid_F), 32'(vld));
    chk({tag, "_pc"},    PC_F, e_pc);
    chk({tag, "_instr"}, instr_F, vld ? word_of(pc) : 32'h0);
    chk({tag, "_pc4"},   PC_plus4_F, e_pc + 32'd4);
  endtask

  task automatic step(input logic st, input logic src, input logic [31:0] tgt, input logic gnt);
    @(negedge clk);
    stall_F     = st;
    PC_src_D    = src;
    PC_Target_D = tgt;
    imem_gnt    = gnt;
    #1;
  endtask

  task automatic do_reset(input int strays);
    @(negedge clk);
    rst_n = 1'b0;
    stall_F = 1'b0;
    PC_src_D = 1'b0;
    PC_Target_D = 32'h0;
    imem_gnt = 1'b1;
    #1;
    chk_vec("rst", 1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    @(posedge clk);
    #1;
    stray_req = stray_req + strays;
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time exhausted, expected finish");
    $fatal(1);
  end

  initial begin
    tab_a = '{
      '{1'b0, 1'b1, 32'd0,  1'b0, 32'd0},  '{1'b0, 1'b1, 32'd4,  1'b0, 32'd0},
      '{1'b0, 1'b1, 32'd8,  1'b1, 32'd0},  '{1'b0, 1'b1, 32'd12, 1'b1, 32'd4},
      '{1'b0, 1'b1, 32'd16, 1'b1, 32'd8},  '{1'b0, 1'b1, 32'd20, 1'b1, 32'd12},
      '{1'b0, 1'b1, 32'd24, 1'b1, 32'd16}, '{1'b0, 1'b1, 32'd28, 1'b1, 32'd20}
    };
    tab_b = '{
      '{1'b1, 1'b1, 32'd0,  1'b0, 32'd0},  '{1'b1, 1'b1, 32'd4,  1'b0, 32'd0},
      '{1'b1, 1'b1, 32'd8,  1'b1, 32'd0},  '{1'b1, 1'b1, 32'd12, 1'b1, 32'd0},
      '{1'b1, 1'b0, 32'd16, 1'b1, 32'd0},  '{1'b1, 1'b0, 32'd16, 1'b1, 32'd0},
      '{1'b1, 1'b0, 32'd16, 1'b1, 32'd0},  '{1'b1, 1'b0, 32'd16, 1'b1, 32'd0},
      '{1'b1, 1'b0, 32'd16, 1'b1, 32'd0},  '{1'b1, 1'b0, 32'd16, 1'b1, 32'd0},
      '{1'b0, 1'b0, 32'd16, 1'b1, 32'd0},  '{1'b0, 1'b1, 32'd16, 1'b1, 32'd4},
      '{1'b0, 1'b1, 32'd20, 1'b1, 32'd8},  '{1'b0, 1'b1, 32'd24, 1'b1, 32'd12},
      '{1'b0, 1'b1, 32'd28, 1'b1, 32'd16}, '{1'b0, 1'b1, 32'd32, 1'b1, 32'd20}
    };

    // Streaming, 1-cycle memory, no stall
    lat = 1;
    do_reset(0);
    for (int i = 0; i < 8; i++) begin
      step(tab_a[i].stall, 1'b0, 32'h0, 1'b1);
      chk_vec($sformatf("A%0d", i), tab_a[i].req, tab_a[i].addr, tab_a[i].vld, tab_a[i].pc);
    end

    // Stall fills buffer to DEPTH, then drains in order
    do_reset(0);
    for (int i = 0; i < 16; i++) begin
      step(tab_b[i].stall, 1'b0, 32'h0, 1'b1);
      chk_vec($sformatf("B%0d", i), tab_b[i].req, tab_b[i].addr, tab_b[i].vld, tab_b[i].pc);
    end

    // Redirect with two 3-cycle requests in flight
    lat = 3;
    do_reset(0);
    step(1'b0, 1'b0, 32'h0, 1'b1);        chk_vec("C0", 1'b1, 32'h0,   1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b1);        chk_vec("C1", 1'b1, 32'h4,   1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h0000_0103, 1'b0); chk_vec("C2", 1'b0, 32'h8,   1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b1);        chk_vec("C3", 1'b1, 32'h100, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b1);        chk_vec("C4", 1'b1, 32'h104, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b1);        chk_vec("C5", 1'b1, 32'h108, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b1);        chk_vec("C6", 1'b1, 32'h10C, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b1);        chk_vec("C7", 1'b0, 32'h110, 1'b1, 32'h100);
    step(1'b0, 1'b0, 32'h0, 1'b1);        chk_vec("C8", 1'b1, 32'h110, 1'b1, 32'h104);

    // Redirect coinciding with a response and a would-be pop, 2-cycle memory
    lat = 2;
    do_reset(0);
    step(1'b0, 1'b0, 32'h0, 1'b1);   chk_vec("D0", 1'b1, 32'h0,   1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b1);   chk_vec("D1", 1'b1, 32'h4,   1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b1);   chk_vec("D2", 1'b1, 32'h8,   1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b1);   chk_vec("D3", 1'b1, 32'hC,   1'b1, 32'h0);
    step(1'b0, 1'b1, 32'h400, 1'b1); chk_vec("D4", 1'b0, 32'h10,  1'b1, 32'h4);
    step(1'b0, 1'b0, 32'h0, 1'b1);   chk_vec("D5", 1'b1, 32'h400, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b1);   chk_vec("D6", 1'b1, 32'h404, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b1);   chk_vec("D7", 1'b1, 32'h408, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b1);   chk_vec("D8", 1'b1, 32'h40C, 1'b1, 32'h400);

    // Back-to-back redirects: latest target wins
    lat = 1;
    do_reset(0);
    step(1'b0, 1'b0, 32'h0, 1'b1);   chk_vec("E0", 1'b1, 32'h0,   1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h200, 1'b1); chk_vec("E1", 1'b0, 32'h4,   1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h300, 1'b1); chk_vec("E2", 1'b0, 32'h200, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b1);   chk_vec("E3", 1'b1, 32'h300, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b1);   chk_vec("E4", 1'b1, 32'h304, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b1);   chk_vec("E5", 1'b1, 32'h308, 1'b1, 32'h300);
    step(1'b0, 1'b0, 32'h0, 1'b1);   chk_vec("E6", 1'b1, 32'h30C, 1'b1, 32'h304);

    // Reset with a full buffer, then an unsolicited response right after release
    do_reset(0);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 32'h0, 1'b1);
    chk_vec("F_full", 1'b0, 32'h10, 1'b1, 32'h0);
    do_reset(1);
    step(1'b0, 1'b0, 32'h0, 1'b1);   chk_vec("F0", 1'b1, 32'h0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b1);   chk_vec("F1", 1'b1, 32'h4, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b1);   chk_vec("F2", 1'b1, 32'h8, 1'b1, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
